fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
//
// PURPOSE
// - Single-clock parametrised FIFO; next generation of the 16-bit fixed-depth FIFO.
// - Adds arbitrary (non-power-of-2) depth, programmable almost-full/almost-empty levels,
//   an occupancy count, read-data valid and full-with-read pass-through.
// - Sits between producer/consumer stages in one clock domain; drop-in for the older FIFO's flag set.
//
// PARAMETERS
// - DATA_WIDTH  16  data word width, >=1
// - DEPTH       16  number of entries, >=2, any integer (need not be a power of 2)
// - AF_LEVEL    14  almost_full asserted when count >= AF_LEVEL; AE_LEVEL < AF_LEVEL <= DEPTH
// - AE_LEVEL     2  almost_empty asserted when count <= AE_LEVEL; 0 <= AE_LEVEL
// - CW  localparam  $clog2(DEPTH+1), count width
//
// PORTS
// - clk           in   1           clock, all state on rising edge
// - rst           in   1           asynchronous, active-high reset
// - data_in       in   DATA_WIDTH  write data
// - write_enable  in   1           write request
// - read_enable   in   1           read request
// - data_out      out  DATA_WIDTH  read data
// - read_valid    out  1           data_out holds a popped word
// - write_ack     out  1           previous-cycle write accepted
// - overflow      out  1           previous-cycle write rejected
// - underflow     out  1           previous-cycle read rejected
// - full          out  1           count == DEPTH
// - empty         out  1           count == 0
// - almost_full   out  1           count >= AF_LEVEL
// - almost_empty  out  1           count <= AE_LEVEL
// - count         out  CW          current occupancy 0..DEPTH
//
// BEHAVIOUR
// - Reset (async assert, released synchronously by the integrator):
//   - wr_ptr=rd_ptr=count=0, data_out=0
//   - read_valid=write_ack=overflow=underflow=0
//   - empty=1, almost_empty=1, full=0, almost_full=0
//   - Memory contents are not reset.
//   - Reset mid-operation discards all stored words; no pulse outputs survive reset.
// - Acceptance, evaluated on pre-edge state:
//   - rd_acc = read_enable && !empty
//   - wr_acc = write_enable && (!full || rd_acc); full with a simultaneous read accepts both.
//   - Empty with a simultaneous read and write accepts the write only and flags underflow.
// - Pointers: increment on accept; wrap DEPTH-1 -> 0 explicitly (no power-of-2 masking).
// - count_next = count + wr_acc - rd_acc; never exceeds DEPTH and never underflows below 0.
// - full, empty, almost_full and almost_empty are decoded from the registered count.
//   They update in the cycle after the accepting edge.
// - write_ack = wr_acc, registered: a 1-cycle pulse in the cycle after the request.
// - overflow = write_enable && !wr_acc, registered: 1-cycle pulse.
// - underflow = read_enable && !rd_acc, registered: 1-cycle pulse.
// - Standard read mode (macro off):
//   - data_out <= mem[rd_ptr] on rd_acc; read_valid <= rd_acc.
//   - Latency is 1 cycle. data_out holds its last value when no read is accepted.
// - No FSM beyond pointer/count state; write data is never corrupted by a rejected operation.
//
// CONFIGURATION
// - FIFO_FWFT_EN defined: first-word-fall-through.
//   - data_out = mem[rd_ptr] (combinational) and read_valid = !empty.
//   - read_enable acknowledges the displayed word and advances rd_ptr.
//   - A word written into an empty FIFO appears on data_out the cycle after write.
//   - Flag, ack and count timing is unchanged.
// - FIFO_FWFT_EN undefined: standard registered-read mode as above.
//
// TESTING
// - Reset: assert rst mid-stream with count=5.
//   - Response: count=0, empty=1, almost_empty=1, all pulses 0 immediately (async).
// - Fill: 16 writes 0x0001..0x0010 with DEPTH=16.
//   - write_ack on each; almost_full from count=14; full at 16.
//   - 17th write -> overflow=1 for one cycle; count stays 16.
// - Drain: 16 reads.
//   - Standard: data 0x0001..0x0010 in order, each 1 cycle after read_enable.
//   - FWFT: data on the same cycle as read_enable.
//   - Extra read -> underflow=1; empty=1.
// - Full with simultaneous read and write:
//   - Both accepted; count stays 16; write_ack=1; overflow=0.
//   - Popped word is the oldest; written word is read out last.
// - Empty with simultaneous read and write:
//   - Write accepted (count=1); underflow=1.
//   - Next read returns the written word.
// - Wrap with DEPTH=5 (non-power-of-2):
//   - 3 writes/3 reads repeated 4 times; pointers wrap 4->0.
//   - Data order preserved; count never exceeds 5.
//   - Existing overflow/underflow/ack SVA pass.

Source files
------------

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty levels, occupancy count and registered status pulses.
// Optional build macro FIFO_FWFT_EN selects first-word-fall-through reads;
// when undefined, reads are registered with one cycle of latency.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  read_valid,
    output logic                  write_ack,
    output logic                  overflow,
    output logic                  underflow,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [CW-1:0]         count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  rd_acc;
    logic                  wr_acc;

    // A full FIFO can still take a write when a read frees a slot on the same edge.
    assign rd_acc = read_enable && !empty;
    assign wr_acc = write_enable && (!full || rd_acc);

    // Status flags are pure decodes of the registered occupancy.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Pointers, occupancy and one-cycle status pulses; pointers wrap explicitly
    // because DEPTH need not be a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            write_ack <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (wr_ptr == PW'(DEPTH - 1)) begin
                    wr_ptr <= '0;
                end else begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
            end
            if (rd_acc) begin
                if (rd_ptr == PW'(DEPTH - 1)) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
            end
            count     <= count + CW'(wr_acc) - CW'(rd_acc);
            write_ack <= wr_acc;
            overflow  <= write_enable && !wr_acc;
            underflow <= read_enable && !rd_acc;
        end
    end

    // Storage array; never reset, written only by an accepted write.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always presented; read_enable just acknowledges it.
    assign data_out   = mem[rd_ptr];
    assign read_valid = !empty;
`else
    // Registered read: data_out updates only on an accepted read, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            read_valid <= 1'b0;
        end else begin
            if (rd_acc) begin
                data_out <= mem[rd_ptr];
            end
            read_valid <= rd_acc;
        end
    end
`endif

`ifndef SYNTHESIS
    a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
    a_ack_xor_ovf: assert property (@(posedge clk) disable iff (rst) !(write_ack && overflow));
    a_full_empty:  assert property (@(posedge clk) disable iff (rst) !(full && empty));
    a_ptr_range:   assert property (@(posedge clk) disable iff (rst)
                                    (wr_ptr <= PW'(DEPTH - 1)) && (rd_ptr <= PW'(DEPTH - 1)));
`endif

endmodule

// File: tb/tb_fifo_sync_param.sv
// Testbench for fifo_sync_param: a DEPTH=16 instance and a DEPTH=5 instance
// share the same stimulus; each is compared against a queue-based reference.
module tb_fifo_sync_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        write_enable;
    logic        read_enable;

    logic [15:0] data_out_a, data_out_b;
    logic        read_valid_a, write_ack_a, overflow_a, underflow_a;
    logic        full_a, empty_a, almost_full_a, almost_empty_a;
    logic [4:0]  count_a;
    logic        read_valid_b, write_ack_b, overflow_b, underflow_b;
    logic        full_b, empty_b, almost_full_b, almost_empty_b;
    logic [2:0]  count_b;

    int errors = 0;
    int checks = 0;

    // reference state: queues hold stored words, plus last-cycle pulse values
    logic [15:0] q_a[$], q_b[$];
    logic        rv_a, ack_a, ovf_a, udf_a, rv_b, ack_b, ovf_b, udf_b;
    logic [15:0] dout_a, dout_b;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable),
        .read_enable(read_enable), .data_out(data_out_a), .read_valid(read_valid_a),
        .write_ack(write_ack_a), .overflow(overflow_a), .underflow(underflow_a),
        .full(full_a), .empty(empty_a), .almost_full(almost_full_a),
        .almost_empty(almost_empty_a), .count(count_a)
    );

    fifo_sync_param #(.DATA_WIDTH(16), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(1)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .write_enable(write_enable),
        .read_enable(read_enable), .data_out(data_out_b), .read_valid(read_valid_b),
        .write_ack(write_ack_b), .overflow(overflow_b), .underflow(underflow_b),
        .full(full_b), .empty(empty_b), .almost_full(almost_full_b),
        .almost_empty(almost_empty_b), .count(count_b)
    );

    function automatic void model_clear();
        q_a.delete(); q_b.delete();
        {rv_a, ack_a, ovf_a, udf_a, rv_b, ack_b, ovf_b, udf_b} = '0;
        dout_a = '0; dout_b = '0;
    endfunction

    function automatic void model_update(input bit w, input bit r, input logic [15:0] d);
        bit ra, wa;
        ra = r && (q_a.size() > 0);
        wa = w && ((q_a.size() < 16) || ra);
        rv_a = ra; ack_a = wa; ovf_a = w && !wa; udf_a = r && !ra;
        if (ra) dout_a = q_a.pop_front();
        if (wa) q_a.push_back(d);
        ra = r && (q_b.size() > 0);
        wa = w && ((q_b.size() < 5) || ra);
        rv_b = ra; ack_b = wa; ovf_b = w && !wa; udf_b = r && !ra;
        if (ra) dout_b = q_b.pop_front();
        if (wa) q_b.push_back(d);
    endfunction

    function automatic logic [28:0] exp_a();
        logic rv;
        logic [15:0] d;
`ifdef FIFO_FWFT_EN
        rv = (q_a.size() > 0);
        d  = rv ? q_a[0] : 16'h0;
`else
        rv = rv_a;
        d  = dout_a;
`endif
        return {rv, ack_a, ovf_a, udf_a, q_a.size() == 16, q_a.size() == 0,
                q_a.size() >= 14, q_a.size() <= 2, 5'(q_a.size()), d};
    endfunction

    function automatic logic [28:0] obs_a();
        logic [15:0] d;
        d = data_out_a;
`ifdef FIFO_FWFT_EN
        if (q_a.size() == 0) d = 16'h0;
`endif
        return {read_valid_a, write_ack_a, overflow_a, underflow_a, full_a, empty_a,
                almost_full_a, almost_empty_a, count_a, d};
    endfunction

    function automatic logic [26:0] exp_b();
        logic rv;
        logic [15:0] d;
`ifdef FIFO_FWFT_EN
        rv = (q_b.size() > 0);
        d  = rv ? q_b[0] : 16'h0;
`else
        rv = rv_b;
        d  = dout_b;
`endif
        return {rv, ack_b, ovf_b, udf_b, q_b.size() == 5, q_b.size() == 0,
                q_b.size() >= 4, q_b.size() <= 1, 3'(q_b.size()), d};
    endfunction

    function automatic logic [26:0] obs_b();
        logic [15:0] d;
        d = data_out_b;
`ifdef FIFO_FWFT_EN
        if (q_b.size() == 0) d = 16'h0;
`endif
        return {read_valid_b, write_ack_b, overflow_b, underflow_b, full_b, empty_b,
                almost_full_b, almost_empty_b, count_b, d};
    endfunction

    // drive one cycle of stimulus, then advance the reference past the same edge
    task automatic step(input bit w, input bit r, input logic [15:0] d);
        write_enable = w; read_enable = r; data_in = d;
        @(posedge clk); #1;
        model_update(w, r, d);
    endtask

    task automatic test_reset();
        rst = 1'b1; write_enable = 0; read_enable = 0; data_in = '0;
        repeat (2) @(posedge clk); #1;
        model_clear();
        checks++;
        if (obs_a() !== exp_a()) begin errors++; $display("FAIL reset_init_a: got %h want %h", obs_a(), exp_a()); end
        checks++;
        if (obs_b() !== exp_b()) begin errors++; $display("FAIL reset_init_b: got %h want %h", obs_b(), exp_b()); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h0100 + i));
        checks++;
        if (count_a !== 5'd5 || write_ack_a !== 1'b1) begin
            errors++; $display("FAIL reset_prefill: got count=%0d ack=%b want 5 1", count_a, write_ack_a);
        end
        #2 rst = 1'b1;
        #1 model_clear();
        checks++;
        if ({count_a, empty_a, almost_empty_a, write_ack_a, overflow_a, underflow_a, read_valid_a} !== {5'd0, 1'b1, 1'b1, 4'b0}) begin
            errors++; $display("FAIL reset_async: got count=%0d empty=%b ae=%b ack=%b want 0 1 1 0",
                               count_a, empty_a, almost_empty_a, write_ack_a);
        end
        checks++;
        if (obs_b() !== exp_b()) begin errors++; $display("FAIL reset_async_b: got %h want %h", obs_b(), exp_b()); end
        write_enable = 0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 16'(i));
            checks++;
            if (obs_a() !== exp_a()) begin errors++; $display("FAIL fill_vec %0d: got %h want %h", i, obs_a(), exp_a()); end
            checks++;
            if (write_ack_a !== 1'b1 || almost_full_a !== (i >= 14) || full_a !== (i == 16)) begin
                errors++; $display("FAIL fill_flags %0d: got ack=%b af=%b full=%b want 1 %b %b",
                                   i, write_ack_a, almost_full_a, full_a, i >= 14, i == 16);
            end
        end
        step(1, 0, 16'h0011);
        checks++;
        if (overflow_a !== 1'b1 || count_a !== 5'd16 || write_ack_a !== 1'b0) begin
            errors++; $display("FAIL fill_overflow: got ovf=%b count=%0d ack=%b want 1 16 0", overflow_a, count_a, write_ack_a);
        end
        step(0, 0, 16'h0);
        checks++;
        if (overflow_a !== 1'b0) begin errors++; $display("FAIL fill_ovf_pulse: got %b want 0", overflow_a); end
        checks++;
        if (obs_b() !== exp_b()) begin errors++; $display("FAIL fill_b: got %h want %h", obs_b(), exp_b()); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
`ifdef FIFO_FWFT_EN
            checks++;
            if (data_out_a !== 16'(i)) begin errors++; $display("FAIL drain_fwft %0d: got %h want %h", i, data_out_a, 16'(i)); end
`endif
            step(0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
            checks++;
            if (data_out_a !== 16'(i) || read_valid_a !== 1'b1) begin
                errors++; $display("FAIL drain_data %0d: got %h rv=%b want %h 1", i, data_out_a, read_valid_a, 16'(i));
            end
`endif
            checks++;
            if (obs_a() !== exp_a()) begin errors++; $display("FAIL drain_vec %0d: got %h want %h", i, obs_a(), exp_a()); end
        end
        step(0, 1, 16'h0);
        checks++;
        if (underflow_a !== 1'b1 || empty_a !== 1'b1) begin
            errors++; $display("FAIL drain_underflow: got udf=%b empty=%b want 1 1", underflow_a, empty_a);
        end
        checks++;
        if (obs_b() !== exp_b()) begin errors++; $display("FAIL drain_b: got %h want %h", obs_b(), exp_b()); end
    endtask

    task automatic test_full_rw();
        logic [15:0] first;
        first = 16'($urandom);
        step(1, 0, first);
        for (int i = 1; i < 16; i++) step(1, 0, 16'($urandom));
        checks++;
        if (full_a !== 1'b1) begin errors++; $display("FAIL full_rw_pre: got full=%b want 1", full_a); end
        step(1, 1, 16'hBEEF);
        checks++;
        if (count_a !== 5'd16 || write_ack_a !== 1'b1 || overflow_a !== 1'b0) begin
            errors++; $display("FAIL full_rw: got count=%0d ack=%b ovf=%b want 16 1 0", count_a, write_ack_a, overflow_a);
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out_a !== first) begin errors++; $display("FAIL full_rw_oldest: got %h want %h", data_out_a, first); end
`endif
        for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
            if (i == 15) begin
                checks++;
                if (data_out_a !== 16'hBEEF) begin errors++; $display("FAIL full_rw_last: got %h want beef", data_out_a); end
            end
`endif
            step(0, 1, 16'h0);
            checks++;
            if (obs_a() !== exp_a()) begin errors++; $display("FAIL full_rw_drain %0d: got %h want %h", i, obs_a(), exp_a()); end
        end
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out_a !== 16'hBEEF) begin errors++; $display("FAIL full_rw_last: got %h want beef", data_out_a); end
`endif
    endtask

    task automatic test_empty_rw();
        step(0, 1, 16'h0);
        step(1, 1, 16'h5A5A);
        checks++;
        if (underflow_a !== 1'b1 || write_ack_a !== 1'b1 || count_a !== 5'd1) begin
            errors++; $display("FAIL empty_rw: got udf=%b ack=%b count=%0d want 1 1 1", underflow_a, write_ack_a, count_a);
        end
        checks++;
        if (obs_b() !== exp_b()) begin errors++; $display("FAIL empty_rw_b: got %h want %h", obs_b(), exp_b()); end
        step(0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
        checks++;
        if (data_out_a !== 16'h5A5A) begin errors++; $display("FAIL empty_rw_data: got %h want 5a5a", data_out_a); end
`endif
        checks++;
        if (obs_a() !== exp_a()) begin errors++; $display("FAIL empty_rw_vec: got %h want %h", obs_a(), exp_a()); end
    endtask

    task automatic test_wrap();
        logic [15:0] w[3];
        for (int rep = 0; rep < 4; rep++) begin
            for (int k = 0; k < 3; k++) begin
                w[k] = 16'($urandom);
                step(1, 0, w[k]);
                checks++;
                if (obs_b() !== exp_b()) begin errors++; $display("FAIL wrap_wr %0d.%0d: got %h want %h", rep, k, obs_b(), exp_b()); end
            end
            for (int k = 0; k < 3; k++) begin
`ifdef FIFO_FWFT_EN
                checks++;
                if (data_out_b !== w[k]) begin errors++; $display("FAIL wrap_data %0d.%0d: got %h want %h", rep, k, data_out_b, w[k]); end
`endif
                step(0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
                checks++;
                if (data_out_b !== w[k]) begin errors++; $display("FAIL wrap_data %0d.%0d: got %h want %h", rep, k, data_out_b, w[k]); end
`endif
                checks++;
                if (obs_b() !== exp_b()) begin errors++; $display("FAIL wrap_rd %0d.%0d: got %h want %h", rep, k, obs_b(), exp_b()); end
            end
        end
    endtask

    task automatic test_random();
        int pw;
        for (int i = 0; i < 600; i++) begin
            pw = ((i / 50) % 2 == 0) ? 75 : 25;
            step($urandom_range(99) < pw, $urandom_range(99) < (100 - pw), 16'($urandom));
            checks++;
            if (obs_a() !== exp_a()) begin errors++; $display("FAIL random_a %0d: got %h want %h", i, obs_a(), exp_a()); end
            checks++;
            if (obs_b() !== exp_b()) begin errors++; $display("FAIL random_b %0d: got %h want %h", i, obs_b(), exp_b()); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_full_rw();
        test_empty_rw();
        test_reset();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
